// File: rtl/dmem_port_if.sv
// Requester-side bus of one DMEM access port.
//
// Signals (direction seen from the requester):
//   req    out  access request, held with we/addr/wdata until gnt
//   we     out  byte write enables, all zero = read
//   addr   out  word address
//   wdata  out  write data
//   gnt    in   access accepted this cycle, completes in this cycle
//   rvalid in   read data valid, one cycle after a read grant
//   rdata  in   read data, zero when rvalid is low
//
// Modports: master = requester (CPU or DMA), slave = arbiter.
interface dmem_port_if #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned BeWidth = DATA_WIDTH / 8;

    logic                  req;
    logic [BeWidth-1:0]    we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port synchronous data BRAM between the CPU load/store port (port 0) and
// the DMA/bootloader port (port 1). One access per cycle; read data returns to the owner one
// cycle after its grant. Default arbitration is fixed priority for port 0 with an aging
// counter that forces a port 1 win after MAX_WAIT consecutive denials.
//
// Build option: define DMEM_ARB_ROUND_ROBIN_EN to replace priority+aging with round-robin
// (1-bit last-grant register; the aging counter is not built).
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   p0_if, p1_if requester buses (dmem_port_if.slave) for CPU and DMA
//   mem_en_o     BRAM enable
//   mem_we_o     BRAM byte write enables
//   mem_addr_o   BRAM word address
//   mem_din_o    BRAM write data
//   mem_dout_i   BRAM read data, valid one cycle after a read enable
//   p0_stall_o   CPU request pending but not granted this cycle
module dmem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_WAIT   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    dmem_port_if.slave              p0_if,
    dmem_port_if.slave              p1_if,
    output logic                    mem_en_o,
    output logic [DATA_WIDTH/8-1:0] mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_din_o,
    input  logic [DATA_WIDTH-1:0]   mem_dout_i,
    output logic                    p0_stall_o
);
    localparam int unsigned BeWidth = DATA_WIDTH / 8;

    logic p0_gnt;
    logic p1_gnt;
    logic contention;

    // Read response tag: one-deep, never stalled.
    logic rd_pend_q, rd_pend_d;
    logic rd_port_q, rd_port_d;

    assign contention = p0_if.req & p1_if.req;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // Last granted port; resets to 1 so port 0 wins the first contention.
    logic last_gnt_q, last_gnt_d;

    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!rst) begin
            if (contention) begin
                if (last_gnt_q) p0_gnt = 1'b1;
                else            p1_gnt = 1'b1;
            end else begin
                p0_gnt = p0_if.req;
                p1_gnt = p1_if.req;
            end
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (p0_gnt)      last_gnt_d = 1'b0;
        else if (p1_gnt) last_gnt_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) last_gnt_q <= 1'b1;
        else     last_gnt_q <= last_gnt_d;
    end
`else
    localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

    // Consecutive cycles port 1 has been requesting without a grant.
    logic [7:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!rst) begin
            if (contention) begin
                if (wait_cnt_q == MaxWait) p1_gnt = 1'b1;
                else                       p0_gnt = 1'b1;
            end else begin
                p0_gnt = p0_if.req;
                p1_gnt = p1_if.req;
            end
        end
    end

    always_comb begin
        wait_cnt_d = 8'd0;
        if (p1_if.req && !p1_gnt) begin
            wait_cnt_d = (wait_cnt_q < MaxWait) ? wait_cnt_q + 8'd1 : wait_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) wait_cnt_q <= 8'd0;
        else     wait_cnt_q <= wait_cnt_d;
    end
`endif

    // Memory mux: everything zero when nobody is granted.
    always_comb begin
        mem_en_o   = p0_gnt | p1_gnt;
        mem_we_o   = '0;
        mem_addr_o = '0;
        mem_din_o  = '0;
        if (p0_gnt) begin
            mem_we_o   = p0_if.we;
            mem_addr_o = p0_if.addr;
            mem_din_o  = p0_if.wdata;
        end else if (p1_gnt) begin
            mem_we_o   = p1_if.we;
            mem_addr_o = p1_if.addr;
            mem_din_o  = p1_if.wdata;
        end
    end

    always_comb begin
        rd_pend_d = (p0_gnt && (p0_if.we == BeWidth'(0))) ||
                    (p1_gnt && (p1_if.we == BeWidth'(0)));
        rd_port_d = p1_gnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q <= 1'b0;
            rd_port_q <= 1'b0;
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_port_q <= rd_port_d;
        end
    end

    // Gating with rst drops a response whose read was granted just before reset rose.
    always_comb begin
        p0_if.rvalid = rd_pend_q & ~rd_port_q & ~rst;
        p1_if.rvalid = rd_pend_q &  rd_port_q & ~rst;
        p0_if.rdata  = p0_if.rvalid ? mem_dout_i : '0;
        p1_if.rdata  = p1_if.rvalid ? mem_dout_i : '0;
        p0_if.gnt    = p0_gnt;
        p1_if.gnt    = p1_gnt;
        p0_stall_o   = p0_if.req & ~p0_gnt;
    end
endmodule
